// File: rtl/axi_rd_buffer.sv
// AXI read-path buffer: an AR FIFO and an R FIFO in one block, plus an
// outstanding-burst counter that throttles AR issue to MAX_OUT in flight
// and flags R last beats that arrive with nothing outstanding.

// Generic FIFO with one-cycle push-to-valid latency. DEPTH=0 gives a
// combinational pass-through.
module axi_rd_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] in_pld_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_pld_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    // Holds ready low through reset and releases it on the first clock after.
    logic init_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) init_q <= 1'b0;
        else         init_q <= 1'b1;
    end

    if (DEPTH == 0) begin : g_pass
        assign out_pld_o   = in_pld_i;
        assign out_valid_o = in_valid_i && init_q;
        assign in_ready_o  = out_ready_i && init_q;
    end else begin : g_fifo
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int CW = $clog2(DEPTH + 1);

        logic [W-1:0]  mem_q [DEPTH];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] cnt_q;
        logic          full, push, pop;

        assign full        = (cnt_q == CW'(DEPTH));
        assign in_ready_o  = init_q && !full;
        assign out_valid_o = (cnt_q != '0);
        assign out_pld_o   = mem_q[rptr_q];
        assign push        = in_valid_i && in_ready_o;
        assign pop         = out_valid_o && out_ready_i;

        // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push) wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
                if (pop)  rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
                if (push && !pop)      cnt_q <= cnt_q + CW'(1);
                else if (pop && !push) cnt_q <= cnt_q - CW'(1);
            end
        end

        // Storage needs no reset; occupancy alone decides what is visible.
        always_ff @(posedge clk_i) begin
            if (push) mem_q[wptr_q] <= in_pld_i;
        end
    end

endmodule

module axi_rd_buffer #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4,
    parameter int USER_W   = 1,
    parameter int AR_DEPTH = 2,
    parameter int R_DEPTH  = 4,
    parameter int MAX_OUT  = 8,
    localparam int AR_W    = ID_W + ADDR_W + USER_W + 29,
    localparam int R_W     = ID_W + DATA_W + USER_W + 2,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [AR_W-1:0]  s_ar_pld_i,
    input  logic             s_ar_valid_i,
    output logic             s_ar_ready_o,
    output logic [AR_W-1:0]  m_ar_pld_o,
    output logic             m_ar_valid_o,
    input  logic             m_ar_ready_i,
    input  logic [R_W-1:0]   m_r_pld_i,
    input  logic             m_r_last_i,
    input  logic             m_r_valid_i,
    output logic             m_r_ready_o,
    output logic [R_W-1:0]   s_r_pld_o,
    output logic             s_r_last_o,
    output logic             s_r_valid_o,
    input  logic             s_r_ready_i,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic             err_underflow_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             can_issue;
    logic             ar_fifo_valid;
    logic             ar_hs, r_last_hs;

    assign can_issue = (cnt_q < CNT_W'(MAX_OUT));

    // Gating the FIFO's pop side also gates s_ar_ready_o in pass-through mode.
    axi_rd_buffer_fifo #(.W(AR_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_pld_i    (s_ar_pld_i),
        .in_valid_i  (s_ar_valid_i),
        .in_ready_o  (s_ar_ready_o),
        .out_pld_o   (m_ar_pld_o),
        .out_valid_o (ar_fifo_valid),
        .out_ready_i (m_ar_ready_i && can_issue)
    );

    assign m_ar_valid_o = ar_fifo_valid && can_issue;

    // Last travels with the payload so bursts stay framed through the buffer.
    axi_rd_buffer_fifo #(.W(R_W + 1), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_pld_i    ({m_r_pld_i, m_r_last_i}),
        .in_valid_i  (m_r_valid_i),
        .in_ready_o  (m_r_ready_o),
        .out_pld_o   ({s_r_pld_o, s_r_last_o}),
        .out_valid_o (s_r_valid_o),
        .out_ready_i (s_r_ready_i)
    );

    assign ar_hs     = m_ar_valid_o && m_ar_ready_i;
    assign r_last_hs = s_r_valid_o && s_r_ready_i && s_r_last_o;

    // Outstanding count: issue adds, completed burst subtracts; a completion
    // with nothing outstanding saturates at zero and latches the error flag.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (ar_hs && !r_last_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (r_last_hs && !ar_hs) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign out_cnt_o       = cnt_q;
    assign err_underflow_o = err_q;

endmodule

// File: tb/tb_axi_rd_buffer.sv
// Scoreboard bench for axi_rd_buffer: directed scenarios then random traffic.
module tb_axi_rd_buffer;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int ID_W     = 4;
    localparam int USER_W   = 1;
    localparam int AR_DEPTH = 3;
    localparam int R_DEPTH  = 4;
    localparam int MAX_OUT  = 2;
    localparam int AR_W     = ID_W + ADDR_W + USER_W + 29;
    localparam int R_W      = ID_W + DATA_W + USER_W + 2;
    localparam int CNT_W    = $clog2(MAX_OUT + 1);

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [AR_W-1:0]  s_ar_pld_i;
    logic             s_ar_valid_i;
    logic             s_ar_ready_o;
    logic [AR_W-1:0]  m_ar_pld_o;
    logic             m_ar_valid_o;
    logic             m_ar_ready_i;
    logic [R_W-1:0]   m_r_pld_i;
    logic             m_r_last_i;
    logic             m_r_valid_i;
    logic             m_r_ready_o;
    logic [R_W-1:0]   s_r_pld_o;
    logic             s_r_last_o;
    logic             s_r_valid_o;
    logic             s_r_ready_i;
    logic [CNT_W-1:0] out_cnt_o;
    logic             err_underflow_o;

    axi_rd_buffer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W),
        .AR_DEPTH(AR_DEPTH), .R_DEPTH(R_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_ar_pld_i(s_ar_pld_i), .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
        .m_ar_pld_o(m_ar_pld_o), .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
        .m_r_pld_i(m_r_pld_i), .m_r_last_i(m_r_last_i), .m_r_valid_i(m_r_valid_i),
        .m_r_ready_o(m_r_ready_o),
        .s_r_pld_o(s_r_pld_o), .s_r_last_o(s_r_last_o), .s_r_valid_o(s_r_valid_o),
        .s_r_ready_i(s_r_ready_i),
        .out_cnt_o(out_cnt_o), .err_underflow_o(err_underflow_o)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Reference model: in-order payload queues and an outstanding-burst tally.
    logic [AR_W-1:0] ar_q [$];
    logic [R_W:0]    r_q  [$];
    int              mcnt = 0;
    bit              merr = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [AR_W-1:0] rnd_ar();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[AR_W-1:0];
    endfunction

    function automatic logic [R_W-1:0] rnd_r();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[R_W-1:0];
    endfunction

    function automatic logic [R_W-1:0] r_with_data(input int k);
        logic [ID_W-1:0] id;
        id = ID_W'($urandom);
        return {id, DATA_W'(k), 2'b00, USER_W'(0)};
    endfunction

    // Monitor: values at the falling edge are what the next rising edge samples.
    initial begin
        logic           ar_hs, r_hs, exp_last;
        logic [AR_W-1:0] ea;
        logic [R_W:0]    er;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                ar_q.delete();
                r_q.delete();
                mcnt = 0;
                merr = 1'b0;
                chk("rst_m_ar_valid", m_ar_valid_o, 0);
                chk("rst_s_r_valid", s_r_valid_o, 0);
                chk("rst_out_cnt", out_cnt_o, 0);
                chk("rst_err", err_underflow_o, 0);
                chk("rst_s_ar_ready", s_ar_ready_o, 0);
                chk("rst_m_r_ready", m_r_ready_o, 0);
            end else begin
                chk("out_cnt", out_cnt_o, mcnt);
                chk("err_underflow", err_underflow_o, merr);
                if (m_ar_valid_o) chk("ar_gate", mcnt < MAX_OUT, 1);
                ar_hs    = m_ar_valid_o && m_ar_ready_i;
                r_hs     = s_r_valid_o && s_r_ready_i;
                exp_last = 1'b0;
                if (ar_hs) begin
                    if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                    else begin
                        ea = ar_q.pop_front();
                        chk("ar_pld", m_ar_pld_o, ea);
                    end
                end
                if (r_hs) begin
                    if (r_q.size() == 0) chk("r_unexpected", 1, 0);
                    else begin
                        er = r_q.pop_front();
                        exp_last = er[0];
                        chk("r_pld", {s_r_pld_o, s_r_last_o}, er);
                    end
                end
                if (s_ar_valid_i && s_ar_ready_o) ar_q.push_back(s_ar_pld_i);
                if (m_r_valid_i && m_r_ready_o)   r_q.push_back({m_r_pld_i, m_r_last_i});
                if (ar_hs && !(r_hs && exp_last)) mcnt++;
                else if (r_hs && exp_last && !ar_hs) begin
                    if (mcnt == 0) merr = 1'b1;
                    else mcnt--;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_r_last();
        m_r_pld_i   = rnd_r();
        m_r_last_i  = 1'b1;
        m_r_valid_i = 1'b1;
        cyc();
        m_r_valid_i = 1'b0;
        m_r_last_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        rst_ni = 1'b0;
        s_ar_pld_i = '0; s_ar_valid_i = 1'b0; m_ar_ready_i = 1'b0;
        m_r_pld_i = '0; m_r_last_i = 1'b0; m_r_valid_i = 1'b0; s_r_ready_i = 1'b0;
        repeat (3) cyc();
        rst_ni = 1'b1;
        cyc();
        chk("ready_after_rst_ar", s_ar_ready_o, 1);
        chk("ready_after_rst_r", m_r_ready_o, 1);

        // Single AR, visible one cycle after push with identical payload.
        s_ar_pld_i   = {4'd3, 32'h1000, 29'd0, 1'b0};
        s_ar_valid_i = 1'b1;
        m_ar_ready_i = 1'b1;
        cyc();
        s_ar_valid_i = 1'b0;
        chk("ar_latency", m_ar_valid_o, 1);
        chk("ar_first_pld", m_ar_pld_o, {4'd3, 32'h1000, 29'd0, 1'b0});
        cyc();
        chk("cnt_one", out_cnt_o, 1);

        // Two more ARs: second issues, third held at MAX_OUT.
        s_ar_valid_i = 1'b1;
        s_ar_pld_i = rnd_ar(); cyc();
        s_ar_pld_i = rnd_ar(); cyc();
        s_ar_valid_i = 1'b0;
        cyc(); cyc();
        chk("ar_held", m_ar_valid_o, 0);
        chk("cnt_max", out_cnt_o, 2);
        s_r_ready_i = 1'b1;
        send_r_last();
        cyc();
        chk("ar_released", m_ar_valid_o, 1);
        cyc();
        chk("cnt_back_max", out_cnt_o, 2);

        // Bring count to 1, then issue an AR and retire a burst in one cycle.
        send_r_last();
        cyc(); cyc();
        chk("cnt_before_simul", out_cnt_o, 1);
        m_ar_ready_i = 1'b0;
        s_r_ready_i  = 1'b0;
        s_ar_pld_i   = rnd_ar();
        s_ar_valid_i = 1'b1;
        send_r_last();
        s_ar_valid_i = 1'b0;
        chk("simul_ar_ready", m_ar_valid_o, 1);
        chk("simul_r_ready", s_r_valid_o, 1);
        m_ar_ready_i = 1'b1;
        s_r_ready_i  = 1'b1;
        cyc();
        chk("cnt_simul", out_cnt_o, 1);

        // Retire the last burst, then one more last beat underflows.
        send_r_last();
        cyc(); cyc();
        chk("cnt_zero", out_cnt_o, 0);
        send_r_last();
        cyc();
        chk("underflow_err", err_underflow_o, 1);
        chk("underflow_cnt", out_cnt_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("err_cleared", err_underflow_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // R FIFO fills at four beats; the fifth waits until upstream drains.
        s_r_ready_i = 1'b0;
        m_r_valid_i = 1'b1;
        m_r_last_i  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_r_pld_i = r_with_data(k);
            cyc();
        end
        chk("r_full", m_r_ready_o, 0);
        m_r_pld_i = r_with_data(4);
        cyc(); cyc();
        chk("r_still_full", m_r_ready_o, 0);
        s_r_ready_i = 1'b1;
        chk("r_first_data", s_r_pld_o[USER_W+2 +: DATA_W], 0);
        guard = 0;
        while (!m_r_ready_o && guard < 10) begin cyc(); guard++; end
        if (guard >= 10) chk("r_accept_timeout", 1, 0);
        cyc();
        m_r_valid_i = 1'b0;
        repeat (6) cyc();
        chk("r_drained", s_r_valid_o, 0);

        // Fill the depth-3 AR FIFO, then reset must discard it.
        m_ar_ready_i = 1'b0;
        s_ar_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_ar_pld_i = rnd_ar();
            cyc();
        end
        s_ar_valid_i = 1'b0;
        chk("ar_full", s_ar_ready_o, 0);
        chk("ar_full_valid", m_ar_valid_o, 1);
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("ar_flushed_valid", m_ar_valid_o, 0);
        chk("ar_flushed_ready", s_ar_ready_o, 1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            s_ar_valid_i = 1'($urandom_range(0, 1));
            s_ar_pld_i   = rnd_ar();
            m_ar_ready_i = ($urandom_range(0, 9) < 7);
            m_r_valid_i  = 1'($urandom_range(0, 1));
            m_r_pld_i    = rnd_r();
            m_r_last_i   = ($urandom_range(0, 3) == 0);
            s_r_ready_i  = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 499) == 0) begin
                rst_ni = 1'b0;
                cyc();
                rst_ni = 1'b1;
            end
            cyc();
        end
        s_ar_valid_i = 1'b0;
        m_r_valid_i  = 1'b0;
        s_r_ready_i  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            m_ar_ready_i = 1'b1;
            if (out_cnt_o != 0 && c < 10) begin
                m_r_pld_i = rnd_r(); m_r_last_i = 1'b1; m_r_valid_i = 1'b1;
            end else begin
                m_r_valid_i = 1'b0;
            end
            cyc();
        end
        m_r_valid_i = 1'b0;
        repeat (10) cyc();
        chk("final_ar_q_empty", ar_q.size(), 0);
        chk("final_r_q_empty", r_q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/axi_rd_buffer.md
AXI_RD_BUFFER -- requirements
Module: axi_rd_buffer

Interface
REQ-001 The block SHALL have one clock, clk_i, and an asynchronous, active-low reset, rst_ni.
REQ-002 Parameter ADDR_W, default 32, SHALL set the AXI address width.
REQ-003 Parameter DATA_W, default 64, SHALL set the AXI data width.
REQ-004 Parameters ID_W and USER_W, default 4 and 1, SHALL set the ID and user widths.
REQ-005 Parameters AR_DEPTH and R_DEPTH, default 2 and 4, range 0..64, SHALL set the FIFO entries per channel; 0 SHALL mean combinational pass-through.
REQ-006 Parameter MAX_OUT, default 8, range 1..255, SHALL set the maximum number of outstanding read bursts.
REQ-007 Derived widths SHALL be AR_W = ID_W+ADDR_W+USER_W+29 ({id,addr,len,size,burst,lock,cache,prot,qos,region,user}, MSB first), R_W = ID_W+DATA_W+USER_W+2 ({id,data,resp,user}), and CNT_W = $clog2(MAX_OUT+1).
REQ-008 The ports SHALL be, as name / direction / width / meaning:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- s_ar_pld_i  in  AR_W  upstream AR payload
- s_ar_valid_i  in  1  upstream AR valid
- s_ar_ready_o  out  1  upstream AR ready
- m_ar_pld_o  out  AR_W  downstream AR payload
- m_ar_valid_o  out  1  downstream AR valid
- m_ar_ready_i  in  1  downstream AR ready
- m_r_pld_i  in  R_W  downstream R payload
- m_r_last_i  in  1  downstream R last
- m_r_valid_i  in  1  downstream R valid
- m_r_ready_o  out  1  downstream R ready
- s_r_pld_o  out  R_W  upstream R payload
- s_r_last_o  out  1  upstream R last
- s_r_valid_o  out  1  upstream R valid
- s_r_ready_i  in  1  upstream R ready
- out_cnt_o  out  CNT_W  outstanding bursts
- err_underflow_o  out  1  sticky: R last received with zero outstanding

Function
REQ-009 Each channel SHALL be a FIFO that accepts on valid&&ready at the input and releases on valid&&ready at the output, preserving order and payload bit-exactly.
REQ-010 For DEPTH>=1:
- ready SHALL equal !full and SHALL depend on registered state only;
- output valid SHALL equal !empty;
- latency from push to output-valid SHALL be 1 cycle.
REQ-011 For DEPTH>=1, a push and a pop in the same cycle SHALL leave occupancy unchanged, and when full no push SHALL be accepted even if a pop occurs that cycle.
REQ-012 For DEPTH=0, payload, valid and ready SHALL be wired through combinationally.
REQ-013 The read and write pointers SHALL wrap modulo DEPTH, including for non-power-of-2 depths.
REQ-014 The AR output SHALL be gated: m_ar_valid_o = AR FIFO non-empty && out_cnt_o < MAX_OUT. When DEPTH=0, s_ar_ready_o SHALL also be gated by out_cnt_o < MAX_OUT.
REQ-015 out_cnt_o SHALL:
- increment on an m_ar handshake;
- decrement on an s_r handshake with s_r_last_o=1;
- stay unchanged when both occur in the same cycle.
REQ-016 A last-beat s_r handshake while out_cnt_o==0 with no simultaneous increment SHALL hold out_cnt_o at 0 and set err_underflow_o until reset.
REQ-017 m_r_ready_o SHALL follow REQ-010 for the R FIFO and SHALL NOT depend on out_cnt_o.

Reset
REQ-018 While rst_ni is low, the following SHALL be 0 asynchronously: all FIFO pointers and occupancies, out_cnt_o, err_underflow_o, m_ar_valid_o and s_r_valid_o.
REQ-019 s_ar_ready_o and m_r_ready_o SHALL be 0 during reset and SHALL go to 1 in the first cycle after release (DEPTH>=1).
REQ-020 Reset asserted mid-burst SHALL discard all buffered entries; no stale entry SHALL be presented after release.

Verification
REQ-021 With defaults, push AR id=3 addr=0x1000 with m_ar_ready_i=1 -> m_ar_valid_o high 1 cycle later with identical payload, and out_cnt_o=1.
REQ-022 With MAX_OUT=2, issue 3 ARs and return no R -> third AR held (m_ar_valid_o=0), out_cnt_o=2; one R beat with last=1 -> third AR issued next cycle, and out_cnt_o stays 2.
REQ-023 With R_DEPTH=4 and s_r_ready_i=0, drive 5 R beats -> m_r_ready_o=0 after the 4th; then release s_r_ready_i -> beats emerge in order, data 0..4.
REQ-024 In the same cycle, complete an AR handshake and an R last-beat handshake with out_cnt_o=1 -> out_cnt_o stays 1.
REQ-025 Drive an R last beat with out_cnt_o=0 -> err_underflow_o=1 and out_cnt_o=0; assert reset -> err_underflow_o=0.
REQ-026 With AR_DEPTH=3, fill the FIFO, assert rst_ni=0 for 1 cycle, then release -> m_ar_valid_o=0 and s_ar_ready_o=1.
